lcd_sequencer: RTL

- Downstream consumer of the LSU's LCD control register output (o_io_lcd).
- Turns software writes to that register into correctly timed HD44780-style bus cycles: address setup, enable pulse, hold, then command execution wait.
- Runs a fixed power-up init sequence.
- Buffers one request that arrives while busy, and exposes busy and overrun status to the pins and the SoC.

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_timer.sv | 24 ++
 rtl/lcd_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD sequencer.
package lcd_pkg;

    // Bus-cycle FSM states
    typedef enum logic [2:0] {
        StPwrup,
        StIdle,
        StSetup,
        StEnh,
        StHold,
        StWait
    } lcd_state_e;

    // Power-up init: function set, display on, clear, entry mode (all RS=0)
    localparam int unsigned INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Field positions inside the LSU LCD register
    localparam int unsigned LCD_DATA_LSB = 0;
    localparam int unsigned LCD_STRB_BIT = 8;
    localparam int unsigned LCD_RS_BIT   = 9;
    localparam int unsigned LCD_ON_BIT   = 31;

    // Clear display and return home need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done while the count sits at zero, never wraps.
module lcd_timer #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; the owner asserts load during its reset
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            cnt_q <= i_load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// Converts LCD register writes into timed HD44780 bus cycles with power-up
// init, a one-deep pending slot, and busy/overrun status.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_SHORT = 2000,
    parameter int unsigned T_LONG  = 82000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overrun
);

    lcd_state_e       state_q, state_d;
    logic             strb_prev_q;
    logic             slot_full_q, slot_full_d;
    logic [8:0]       slot_word_q, slot_word_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic             in_init_q, in_init_d;
    logic [7:0]       data_q;
    logic             rs_q, en_q, on_q;

    logic             req;
    logic [8:0]       req_word;
    logic             launch;
    logic [8:0]       launch_word;
    logic [1:0]       idx_next;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;

    logic unused_reg_bits;
    assign unused_reg_bits = ^i_lcd_reg[30:10];

    // Rising edge of the strobe bit is one request; a held level is not
    assign req      = i_lcd_reg[LCD_STRB_BIT] & ~strb_prev_q;
    assign req_word = {i_lcd_reg[LCD_RS_BIT], i_lcd_reg[LCD_DATA_LSB +: 8]};
    assign idx_next = init_idx_q + 2'd1;

    lcd_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_load    (tmr_load),
        .i_load_val(tmr_val),
        .o_done    (tmr_done)
    );

    // Next state, pending slot, init progress and timer reloads
    always_comb begin
        state_d     = state_q;
        slot_full_d = slot_full_q;
        slot_word_d = slot_word_q;
        overrun_d   = overrun_q;
        init_idx_d  = init_idx_q;
        in_init_d   = in_init_q;
        launch      = 1'b0;
        launch_word = '0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        // Requests seen outside IDLE go to the slot or are dropped
        if (state_q != StIdle && req) begin
            if (!slot_full_q) begin
                slot_full_d = 1'b1;
                slot_word_d = req_word;
            end else begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StPwrup: begin
                if (tmr_done) begin
                    launch      = 1'b1;
                    launch_word = {1'b0, INIT_ROM[0]};
                end
            end
            StIdle: begin
                if (slot_full_q) begin
                    launch      = 1'b1;
                    launch_word = slot_word_q;
                    slot_full_d = req;
                    slot_word_d = req ? req_word : slot_word_q;
                end else if (req) begin
                    launch      = 1'b1;
                    launch_word = req_word;
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    state_d  = StEnh;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_EN - 1);
                end
            end
            StEnh: begin
                if (tmr_done) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_HOLD - 1);
                end
            end
            StHold: begin
                if (tmr_done) begin
                    state_d  = StWait;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(T_LONG - 1)
                                                         : CNT_W'(T_SHORT - 1);
                end
            end
            StWait: begin
                if (tmr_done) begin
                    if (in_init_q && init_idx_q != 2'(INIT_LEN - 1)) begin
                        init_idx_d  = idx_next;
                        launch      = 1'b1;
                        launch_word = {1'b0, INIT_ROM[idx_next]};
                    end else begin
                        in_init_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StPwrup;
        endcase

        if (launch) begin
            state_d  = StSetup;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_SETUP - 1);
        end

        // Arm the power-up delay while reset is held
        if (i_reset) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_PWRUP - 1);
        end
    end

    // State and registered pin outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StPwrup;
            strb_prev_q <= 1'b0;
            slot_full_q <= 1'b0;
            slot_word_q <= '0;
            overrun_q   <= 1'b0;
            init_idx_q  <= '0;
            in_init_q   <= 1'b1;
            data_q      <= '0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            strb_prev_q <= i_lcd_reg[LCD_STRB_BIT];
            slot_full_q <= slot_full_d;
            slot_word_q <= slot_word_d;
            overrun_q   <= overrun_d;
            init_idx_q  <= init_idx_d;
            in_init_q   <= in_init_d;
            if (launch) begin
                rs_q   <= launch_word[8];
                data_q <= launch_word[7:0];
            end
            en_q <= (state_d == StEnh);
            on_q <= i_lcd_reg[LCD_ON_BIT];
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_busy     = (state_q != StIdle) || slot_full_q;
    assign o_overrun  = overrun_q;

endmodule
